sar_adc_ctrl: RTL and testbench



---
 rtl/sar_adc_ctrl.sv | 156 +++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller with comparator synchronizer
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    // Cycles spent on each bit: DAC/comparator settling plus synchronizer latency.
    localparam int T_BIT = SETTLE_CYCLES + SYNC_STAGES;
    localparam int C_MAX = (SAMPLE_CYCLES > T_BIT) ? SAMPLE_CYCLES : T_BIT;
    localparam int CW    = $clog2(C_MAX + 1);
    localparam int IW    = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_TRIAL  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [WIDTH-1:0]       work;
    logic [WIDTH-1:0]       res_q;
    logic                   valid_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_s;
    logic [WIDTH-1:0]       bit_mask;
    logic [WIDTH-1:0]       work_next;

    // Comparator output is asynchronous to clk; it is only ever used after this chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
        end
    end

    assign cmp_s     = sync_q[SYNC_STAGES-1];
    assign bit_mask  = WIDTH'(1) << idx;
    assign work_next = cmp_s ? (work | bit_mask) : (work & ~bit_mask);

    // Conversion sequencer: sample phase, one trial per bit MSB first, one-cycle done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= IW'(WIDTH - 1);
            work    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ena && start) begin
                        state   <= ST_SAMPLE;
                        cnt     <= CW'(SAMPLE_CYCLES - 1);
                        valid_q <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    if (!ena) begin
                        // Abort: drop back to idle with the DAC parked at zero.
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        idx     <= IW'(WIDTH - 1);
                        work    <= '0;
                        valid_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= ST_TRIAL;
                        cnt   <= CW'(T_BIT - 1);
                        idx   <= IW'(WIDTH - 1);
                        work  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_TRIAL: begin
                    if (!ena) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        idx     <= IW'(WIDTH - 1);
                        work    <= '0;
                        valid_q <= 1'b0;
                    end else if (cnt == '0) begin
                        // Decision edge: keep or clear the trial bit.
                        work <= work_next;
                        if (idx == '0) begin
                            state   <= ST_DONE;
                            res_q   <= work_next;
                            valid_q <= 1'b1;
                            idx     <= IW'(WIDTH - 1);
                        end else begin
                            idx <= idx - 1'b1;
                            cnt <= CW'(T_BIT - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    // DONE: back-to-back conversion if start is still requested.
                    if (ena && start) begin
                        state   <= ST_SAMPLE;
                        cnt     <= CW'(SAMPLE_CYCLES - 1);
                        valid_q <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output decode from the registered state; idle/done show the last working value.
    always_comb begin
        sample   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        dac_code = work;
        case (state)
            ST_SAMPLE: begin
                sample   = 1'b1;
                busy     = 1'b1;
                dac_code = '0;
            end
            ST_TRIAL: begin
                busy     = 1'b1;
                dac_code = work | bit_mask;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                dac_code = work;
            end
        endcase
    end

    assign valid  = valid_q;
    assign result = res_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl
module tb_sar_adc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       cmp_in;
    logic       sample;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic       valid;
    logic [7:0] result;

    // Comparator model: mode 0 = analog input vs DAC (DAC threshold half an LSB
    // below the code, so vin >= code trips it), 1 = tied low, 2 = tied high.
    // flip inverts the comparator to inject a glitch.
    logic [7:0] vin;
    logic [1:0] mode;
    logic       flip;

    int tests;
    int fails;

    typedef struct {
        logic [7:0] vin;
        logic [1:0] mode;
        logic [7:0] exp_res;
    } vec_t;

    vec_t tbl[8];

    sar_adc_ctrl #(
        .WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp_in(cmp_in),
        .sample(sample), .dac_code(dac_code), .busy(busy), .done(done),
        .valid(valid), .result(result)
    );

    assign cmp_in = flip ^ ((mode == 2'd0) ? (dac_code <= vin) : (mode == 2'd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_cmp(input logic [7:0] c);
        if (mode == 2'd0) return c <= vin;
        return mode == 2'd2;
    endfunction

    // One conversion from a start pulse; checks latency, trial codes and result.
    task automatic run_conv(input logic [7:0] v, input logic [1:0] m, input logic [7:0] exp_res,
                            input bit glitch, input bit repulse, input string tag);
        logic [7:0] w;
        logic [7:0] c;
        logic [7:0] exp_seq[8];
        int         lat;
        bit         seq_ok;
        bit         excl_ok;
        vin  = v;
        mode = m;
        w    = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            c = w | (8'd1 << i);
            exp_seq[7-i] = c;
            if (model_cmp(c)) w = c;
        end
        seq_ok  = 1'b1;
        excl_ok = 1'b1;
        lat     = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " sample/busy/valid at entry"}, {29'd0, sample, busy, valid}, 32'h6);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            flip = 1'b0;
            if (sample && done) excl_ok = 1'b0;
            if (n >= 4 && n < 36 && ((n - 4) % 4) == 0) begin
                if (dac_code !== exp_seq[(n-4)/4]) seq_ok = 1'b0;
                if (glitch) flip = 1'b1;
            end
            if (repulse) start = (n == 15 || n == 30);
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        flip  = 1'b0;
        check({tag, " latency"}, lat, 36);
        check({tag, " trial codes"}, {31'd0, seq_ok}, 32'd1);
        check({tag, " sample/done exclusive"}, {31'd0, excl_ok}, 32'd1);
        check({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
        check({tag, " done state outputs"}, {22'd0, busy, valid, dac_code}, {22'd0, 2'b01, exp_res});
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [7:0] rv;
        int         gap;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        vin   = 8'h00;
        mode  = 2'd0;
        flip  = 1'b0;

        tbl[0] = '{8'hA5, 2'd0, 8'hA5};
        tbl[1] = '{8'hA5, 2'd1, 8'h00};
        tbl[2] = '{8'h00, 2'd2, 8'hFF};
        tbl[3] = '{8'h3C, 2'd0, 8'h3C};
        tbl[4] = '{8'h00, 2'd0, 8'h00};
        tbl[5] = '{8'hFF, 2'd0, 8'hFF};
        tbl[6] = '{8'h01, 2'd0, 8'h01};
        tbl[7] = '{8'h80, 2'd0, 8'h80};

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {13'd0, sample, busy, done, valid, dac_code, result}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle after reset", {13'd0, sample, busy, done, valid, dac_code, result}, 32'h0);

        for (int t = 0; t < 8; t++)
            run_conv(tbl[t].vin, tbl[t].mode, tbl[t].exp_res, 1'b0, 1'b0, $sformatf("vec%0d", t));

        for (int r = 0; r < 6; r++) begin
            rv = 8'($urandom_range(0, 255));
            run_conv(rv, 2'd0, rv, 1'b1, 1'b0, $sformatf("rand%0d_glitch", r));
        end

        run_conv(8'h6B, 2'd0, 8'h6B, 1'b0, 1'b1, "repulse");

        // Back-to-back with start held high.
        vin  = 8'h3C;
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        gap = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            for (int n = 1; n <= 200; n++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    gap = n;
                    break;
                end
            end
            check($sformatf("b2b period %0d", k), gap, 37);
            check($sformatf("b2b result %0d", k), {24'd0, result}, 32'h3C);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b idle", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {13'd0, sample, busy, done, valid, dac_code, result}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) check("no done after reset", {31'd0, done}, 32'd0);
        end
        run_conv(8'hC3, 2'd0, 8'hC3, 1'b0, 1'b0, "post_reset");

        // Abort by ena low during bit 3 after a valid 0x55 result.
        run_conv(8'h55, 2'd0, 8'h55, 1'b0, 1'b0, "pre_abort");
        vin = 8'hEE;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("bit3 trial code", {24'd0, dac_code}, 32'hE8);
        ena = 1'b0;
        @(posedge clk);
        #1;
        check("abort outputs", {12'd0, sample, busy, done, valid, dac_code}, 32'h0);
        check("abort result kept", {24'd0, result}, 32'h55);
        ena = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        check("abort stays idle", {30'd0, busy, valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
